// File: rtl/membus_pkg.sv
// Shared definitions for the memory-bus target: size codes, FSM states,
// decoded regions and the byte-enable helper.
package membus_pkg;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;

    localparam int STATUS_OFS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STALL,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        RG_RAM,
        RG_PORT,
        RG_STAT,
        RG_ERR
    } region_t;

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    byte_en = 4'b0001 << a;
            SZ_H:    byte_en = 4'b0011 << a;
            SZ_W:    byte_en = 4'hF;
            default: byte_en = 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/membus_if.sv
// Request bus between a program engine (master) and the memory target (slave).
interface membus_if;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        valid;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (output addr, size, valid, write, wdata, input rdata, ready, err);
    modport slave  (input addr, size, valid, write, wdata, output rdata, ready, err);
endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO for the TX stream; head byte is presented straight from storage.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Full blocks a push even when a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count[AW];
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/membus_target.sv
// Memory-side bus target: word RAM plus memory-mapped TX FIFO / RX stream port.
// state | meaning
// IDLE  | waiting for valid; request latched on acceptance
// WAIT  | counting down LAT, then completion check
// STALL | port not ready (FIFO full or no RX byte); recheck each cycle
// RESP  | ready (and err/rx_ready) high for one cycle
module membus_target
    import membus_pkg::*;
#(
    parameter int          DEPTH_W    = 256,
    parameter int          LAT        = 1,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] PORT_ADDR  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rstb,
    membus_if.slave     bus,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam int          RW        = $clog2(DEPTH_W);
    localparam int          FW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] STAT_ADDR = PORT_ADDR + 32'(STATUS_OFS);
    localparam logic [7:0]  LAT_INIT  = 8'(LAT);

    state_t         state;
    state_t         state_nx;
    region_t        rg_dec;
    region_t        rg_q;
    logic [7:0]     cnt;
    logic [RW+1:0]  a_q;
    logic [31:0]    wd_q;
    logic [2:0]     sz_q;
    logic           wr_q;
    logic [31:0]    ram [DEPTH_W];
    logic [RW-1:0]  widx;
    logic [3:0]     be;
    logic [31:0]    rd_nx;
    logic           stall;
    logic           go_check;
    logic           go_resp;
    logic           fifo_push;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FW:0]    fifo_count;
    logic [7:0]     push_byte;

    always_comb begin
        rg_dec = RG_RAM;
        if (bus.addr[31:2] == PORT_ADDR[31:2])
            rg_dec = RG_PORT;
        else if (bus.addr[31:2] == STAT_ADDR[31:2])
            rg_dec = RG_STAT;
        else if ({2'b00, bus.addr[31:2]} >= 32'(DEPTH_W))
            rg_dec = RG_ERR;
        if ((bus.size == SZ_H && bus.addr[0]) ||
            (bus.size == SZ_W && bus.addr[1:0] != 2'b00) ||
            (bus.size > SZ_W))
            rg_dec = RG_ERR;
    end

    assign stall   = (rg_q == RG_PORT) && (wr_q ? fifo_full : !rx_valid);
    assign go_resp = go_check && !stall;

    always_comb begin
        state_nx = state;
        go_check = 1'b0;
        case (state)
            ST_IDLE:  if (bus.valid) state_nx = ST_WAIT;
            ST_WAIT:  go_check = (cnt == '0);
            ST_STALL: go_check = 1'b1;
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        if (go_check) state_nx = stall ? ST_STALL : ST_RESP;
    end

    assign widx = a_q[RW+1:2];
    assign be   = byte_en(sz_q, a_q[1:0]);

    always_comb begin
        rd_nx = '0;
        if (!wr_q) begin
            case (rg_q)
                RG_RAM:  rd_nx = ram[widx];
                RG_PORT: rd_nx = {24'd0, rx_data} << {a_q[1:0], 3'b000};
                RG_STAT: rd_nx = {16'd0, 8'(fifo_count), 7'd0, rx_valid};
                default: rd_nx = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a_q       <= '0;
            wd_q      <= '0;
            sz_q      <= '0;
            wr_q      <= 1'b0;
            rg_q      <= RG_RAM;
            bus.rdata <= '0;
            bus.err   <= 1'b0;
            rx_ready  <= 1'b0;
        end else begin
            state    <= state_nx;
            bus.err  <= 1'b0;
            rx_ready <= 1'b0;
            if (state == ST_IDLE && bus.valid) begin
                a_q  <= bus.addr[RW+1:0];
                wd_q <= bus.wdata;
                sz_q <= bus.size;
                wr_q <= bus.write;
                rg_q <= rg_dec;
                cnt  <= LAT_INIT;
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (go_resp) begin
                bus.rdata <= rd_nx;
                bus.err   <= (rg_q == RG_ERR);
                rx_ready  <= (rg_q == RG_PORT) && !wr_q;
            end
        end
    end

    // Store merge lands on the edge that enters RESP, so a reset before it drops the store.
    always_ff @(posedge clk) begin
        if (go_resp && wr_q && rg_q == RG_RAM) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ram[widx][8*i +: 8] <= wd_q[8*i +: 8];
        end
    end

    assign bus.ready = (state == ST_RESP);
    assign fifo_push = go_resp && wr_q && (rg_q == RG_PORT);
    assign push_byte = wd_q[{a_q[1:0], 3'b000} +: 8];
    assign tx_valid  = !fifo_empty;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .push  (fifo_push),
        .din   (push_byte),
        .pop   (tx_ready),
        .dout  (tx_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
